control_main_fsm: RTL and testbench

Multicycle main control state machine for the ARM-subset datapath. Decodes the fetched instruction fields, sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects. Produces the raw `pcs`, `regw`, `memw` and `flagw` strobes that the conditional-execution logic gates with the condition result. Memory accesses stall on a single-bit ready handshake.

---
 rtl/control_pkg.sv | 26 ++
 rtl/control_main_fsm_if.sv | 31 +++
 rtl/control_alu_decoder.sv | 20 ++
 rtl/control_main_fsm.sv | 58 +++++
 tb/tb_control_main_fsm.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared state, opcode, cmd and datapath-select encodings for the ARM-subset control path.
package control_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;
  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
endpackage

// File: rtl/control_main_fsm_if.sv
// control_main_fsm_if: instruction fields and memory handshake in, datapath controls out.
interface control_main_fsm_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       mem_ready;
  logic       irwrite;
  logic       nextpc;
  logic       adrsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic [1:0] immsrc;
  logic [1:0] regsrc;
  logic [1:0] alucontrol;
  logic [1:0] flagw;
  logic       pcs;
  logic       regw;
  logic       memw;
  logic       illegal;
  modport master (
    input  op, funct, rd, mem_ready,
    output irwrite, nextpc, adrsrc, alusrca, alusrcb, resultsrc, immsrc,
           regsrc, alucontrol, flagw, pcs, regw, memw, illegal
  );
  modport slave (
    output op, funct, rd, mem_ready,
    input  irwrite, nextpc, adrsrc, alusrca, alusrcb, resultsrc, immsrc,
           regsrc, alucontrol, flagw, pcs, regw, memw, illegal
  );
endinterface

// File: rtl/control_alu_decoder.sv
// control_alu_decoder: maps execute phase, cmd and S to ALU operation and raw flag-write enables.
module control_alu_decoder
  import control_pkg::*;
(
  input  logic       exec,
  input  logic [3:0] cmd,
  input  logic       s,
  output logic [1:0] alucontrol,
  output logic [1:0] flagw
);
  logic       cmp;
  logic [1:0] alu;
  assign cmp = cmd == CMD_CMP;
  assign alu = (cmd == CMD_SUB || cmp) ? ALU_SUB :
               cmd == CMD_AND ? ALU_AND :
               cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
  assign alucontrol = exec ? alu : ALU_ADD;
  // CV flags only make sense for arithmetic ops; compare always updates all flags
  assign flagw = !exec ? 2'b00 : cmp ? 2'b11 : {s, s & ~alu[1]};
endmodule

// File: rtl/control_main_fsm.sv
// control_main_fsm: multicycle main controller sequencing fetch/decode/execute/memory/writeback.
module control_main_fsm
  import control_pkg::*;
(
  input logic clk,
  input logic rst,
  control_main_fsm_if.master bus
);
  state_t     state;
  logic       exec;
  logic       cmp;
  logic       wb;
  logic       fetch;
  logic [1:0] dec_alu;
  logic [1:0] dec_flagw;
  assign fetch = state == S_FETCH;
  assign exec  = state == S_EXECR || state == S_EXECI;
  assign wb    = state == S_ALUWB || state == S_MEMWB;
  assign cmp   = bus.funct[4:1] == CMD_CMP;
  control_alu_decoder u_alu (
    .exec      (exec),
    .cmd       (bus.funct[4:1]),
    .s         (bus.funct[0]),
    .alucontrol(dec_alu),
    .flagw     (dec_flagw)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_FETCH;
    else
      case (state)
        S_FETCH:          if (bus.mem_ready) state <= S_DECODE;
        S_DECODE:         state <= bus.op == OP_DP  ? (bus.funct[5] ? S_EXECI : S_EXECR) :
                                   bus.op == OP_MEM ? S_MEMADR :
                                   bus.op == OP_BR  ? S_BRANCH : S_FETCH;
        S_EXECR, S_EXECI: state <= cmp ? S_FETCH : S_ALUWB;
        S_MEMADR:         state <= bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:        if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWRITE:       if (bus.mem_ready) state <= S_FETCH;
        default:          state <= S_FETCH;
      endcase
  // strobes are qualified by rst so nothing is written while reset is held
  assign bus.irwrite    = rst & fetch & bus.mem_ready;
  assign bus.nextpc     = rst & fetch & bus.mem_ready;
  assign bus.adrsrc     = state == S_MEMREAD || state == S_MEMWRITE;
  assign bus.alusrca    = fetch || state == S_DECODE;
  assign bus.alusrcb    = (fetch || state == S_DECODE) ? SRCB_FOUR :
                          (state == S_EXECI || state == S_MEMADR || state == S_BRANCH) ? SRCB_IMM : SRCB_RM;
  assign bus.resultsrc  = (fetch || state == S_DECODE || state == S_BRANCH) ? RES_ALU :
                          state == S_MEMWB ? RES_RDATA : RES_ALUOUT;
  assign bus.immsrc     = bus.op;
  assign bus.regsrc     = {bus.op == OP_MEM, bus.op == OP_BR};
  assign bus.alucontrol = dec_alu;
  assign bus.flagw      = rst ? dec_flagw : 2'b00;
  assign bus.pcs        = rst & (state == S_BRANCH || (wb && bus.rd == 4'd15));
  assign bus.regw       = rst & wb;
  assign bus.memw       = rst & (state == S_MEMWRITE);
  assign bus.illegal    = rst & (state == S_DECODE) & (bus.op == OP_ILL);
endmodule

// File: tb/tb_control_main_fsm.sv
// tb_control_main_fsm: directed and randomized instruction sequences checked against a phase-list model.
module tb_control_main_fsm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  control_main_fsm_if bus ();
  control_main_fsm dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef enum {PF, PD, PER, PEI, PAW, PMA, PMR, PMB, PMW, PBR} ph_t;
  typedef struct packed {
    logic       irwrite, nextpc, adrsrc, alusrca;
    logic [1:0] alusrcb, resultsrc, alucontrol, flagw;
    logic       pcs, regw, memw, illegal;
  } outs_t;
  typedef struct {
    ph_t  p;
    logic mr;
  } step_t;
  function automatic logic [1:0] ref_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0100:          return 2'b00;
      4'b0010, 4'b1010: return 2'b01;
      4'b0000:          return 2'b10;
      4'b1100:          return 2'b11;
      default:          return 2'b00;
    endcase
  endfunction
  function automatic outs_t expect_out(input ph_t p, input logic [1:0] op, input logic [5:0] f,
                                       input logic [3:0] rd, input logic mr);
    outs_t o;
    logic [1:0] a;
    o = '0;
    a = ref_alu(f[4:1]);
    case (p)
      PF: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.resultsrc = 2'b10; o.irwrite = mr; o.nextpc = mr; end
      PD: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.resultsrc = 2'b10; o.illegal = (op == 2'b11); end
      PER, PEI: begin
        o.alusrcb    = (p == PEI) ? 2'b01 : 2'b00;
        o.alucontrol = a;
        o.flagw      = (f[4:1] == 4'b1010) ? 2'b11 : {f[0], f[0] & (a == 2'b00 || a == 2'b01)};
      end
      PAW: begin o.regw = 1'b1; o.pcs = (rd == 4'd15); end
      PMA: o.alusrcb = 2'b01;
      PMR: o.adrsrc = 1'b1;
      PMB: begin o.resultsrc = 2'b01; o.regw = 1'b1; o.pcs = (rd == 4'd15); end
      PMW: begin o.adrsrc = 1'b1; o.memw = 1'b1; end
      PBR: begin o.alusrcb = 2'b01; o.resultsrc = 2'b10; o.pcs = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction
  function automatic outs_t observed();
    outs_t g;
    g.irwrite = bus.irwrite; g.nextpc = bus.nextpc; g.adrsrc = bus.adrsrc; g.alusrca = bus.alusrca;
    g.alusrcb = bus.alusrcb; g.resultsrc = bus.resultsrc; g.alucontrol = bus.alucontrol; g.flagw = bus.flagw;
    g.pcs = bus.pcs; g.regw = bus.regw; g.memw = bus.memw; g.illegal = bus.illegal;
    return g;
  endfunction
  task automatic check(input string tag, input outs_t exp);
    outs_t got;
    logic [3:0] sel_exp;
    got = observed();
    sel_exp = {bus.op, bus.op == 2'b01, bus.op == 2'b10};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s outputs: got %p expected %p", tag, got, exp);
    end
    checks++;
    assert ({bus.immsrc, bus.regsrc} === sel_exp) else begin
      errors++;
      $error("FAIL %s immsrc/regsrc: got %b expected %b", tag, {bus.immsrc, bus.regsrc}, sel_exp);
    end
  endtask
  task automatic run(input string name, input logic [1:0] op, input logic [5:0] f,
                     input logic [3:0] rd, input int wf, input int wm);
    step_t q[$];
    ph_t mp;
    repeat (wf) q.push_back('{PF, 1'b0});
    q.push_back('{PF, 1'b1});
    q.push_back('{PD, 1'($urandom)});
    case (op)
      2'b00: begin
        q.push_back('{f[5] ? PEI : PER, 1'($urandom)});
        if (f[4:1] != 4'b1010) q.push_back('{PAW, 1'($urandom)});
      end
      2'b01: begin
        mp = f[0] ? PMR : PMW;
        q.push_back('{PMA, 1'($urandom)});
        repeat (wm) q.push_back('{mp, 1'b0});
        q.push_back('{mp, 1'b1});
        if (f[0]) q.push_back('{PMB, 1'($urandom)});
      end
      2'b10: q.push_back('{PBR, 1'($urandom)});
      default: ;
    endcase
    bus.op = op; bus.funct = f; bus.rd = rd;
    foreach (q[i]) begin
      bus.mem_ready = q[i].mr;
      @(negedge clk);
      check($sformatf("%s[%0d] %s", name, i, q[i].p.name()), expect_out(q[i].p, op, f, rd, q[i].mr));
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    bus.op = 2'b01; bus.funct = 6'd0; bus.rd = 4'd0; bus.mem_ready = 1'b1;
    @(negedge clk);
    check("reset_hold", expect_out(PF, 2'b01, 6'd0, 4'd0, 1'b0));
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    run("adds_reg", 2'b00, 6'b001001, 4'd3, 0, 0);
    run("ldr_pc", 2'b01, 6'b000001, 4'd15, 0, 2);
    run("str_wait", 2'b01, 6'b000000, 4'd2, 1, 1);
    run("branch", 2'b10, 6'b000000, 4'd0, 0, 0);
    run("cmp_s0", 2'b00, 6'b010100, 4'd1, 0, 0);
    run("illegal", 2'b11, 6'b000000, 4'd0, 0, 0);
    run("orr_imm_pc", 2'b00, 6'b111001, 4'd15, 0, 0);
    // reset asserted while a store is waiting on memory
    bus.op = 2'b01; bus.funct = 6'b000000; bus.rd = 4'd4; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_pre_memwrite", expect_out(PMW, 2'b01, 6'b000000, 4'd4, 1'b0));
    #1 bus.mem_ready = 1'b1;
    #1 rst = 1'b0;
    #1 check("rst_async", expect_out(PF, 2'b01, 6'b000000, 4'd4, 1'b0));
    @(negedge clk);
    check("rst_held", expect_out(PF, 2'b01, 6'b000000, 4'd4, 1'b0));
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    run("after_rst_str", 2'b01, 6'b100000, 4'd7, 0, 0);
    for (int n = 0; n < 150; n++) begin
      logic [5:0] f;
      logic [3:0] cmds [5];
      cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
      f = 6'($urandom);
      if ($urandom_range(0, 1) == 1) f[4:1] = cmds[$urandom_range(0, 4)];
      run($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), f, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
